// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the main-FIFO pop scheduler: FSM state encodings,
// default main-FIFO thresholds and the threshold validity rule.
package fifo_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    localparam logic [1:0] AF_DEFAULT = 2'd3;
    localparam logic [1:0] AE_DEFAULT = 2'd1;

    // A usable pair needs a non-zero almost-full strictly above almost-empty.
    function automatic logic thresholds_valid(input logic [1:0] af, input logic [1:0] ae);
        return (af != 2'd0) && (ae < af);
    endfunction

endpackage

// File: rtl/threshold_cfg.sv
// Main-FIFO threshold registers: samples the requested pair while INIT is held
// and commits it (or the defaults, if the pair is unusable) when INIT ends.
module threshold_cfg
    import fifo_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_L,
    input  logic       i_sample,
    input  logic       i_load,
    input  logic [1:0] i_af,
    input  logic [1:0] i_ae,
    output logic [1:0] o_af,
    output logic [1:0] o_ae
);

    logic [1:0] r_af_smp;
    logic [1:0] r_ae_smp;
    logic [1:0] r_af;
    logic [1:0] r_ae;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_af_smp <= AF_DEFAULT;
            r_ae_smp <= AE_DEFAULT;
        end else if (i_sample) begin
            r_af_smp <= i_af;
            r_ae_smp <= i_ae;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_af <= AF_DEFAULT;
            r_ae <= AE_DEFAULT;
        end else if (i_load) begin
            if (thresholds_valid(r_af_smp, r_ae_smp)) begin
                r_af <= r_af_smp;
                r_ae <= r_ae_smp;
            end else begin
                r_af <= AF_DEFAULT;
                r_ae <= AE_DEFAULT;
            end
        end
    end

    assign o_af = r_af;
    assign o_ae = r_ae;

endmodule

// File: rtl/vc_pop_scheduler.sv
// Drains the main FIFO into VC0/VC1, one word in flight, steering by one data bit.
// Optional build macro POP_STATS_EN adds saturating per-VC push counters.
module vc_pop_scheduler
    import fifo_ctrl_pkg::*;
#(
    parameter int DATA_SIZE  = 6,
    parameter int VC_SEL_BIT = 5
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 init,
    input  logic [1:0]           afMF_in,
    input  logic [1:0]           aeMF_in,
    input  logic                 fifo_empty_main,
    input  logic                 fifo_error_main,
    input  logic [DATA_SIZE-1:0] data_demux_vc,
    input  logic                 vc0_pause,
    input  logic                 vc1_pause,
    input  logic                 vc0_error,
    input  logic                 vc1_error,
    output logic [1:0]           afMF_o,
    output logic [1:0]           aeMF_o,
    output logic                 pop_main,
    output logic                 push_vc0,
    output logic                 push_vc1,
    output logic [DATA_SIZE-1:0] data_vc,
    output logic [2:0]           state,
`ifdef POP_STATS_EN
    output logic [7:0]           cnt_vc0,
    output logic [7:0]           cnt_vc1,
`endif
    output logic                 idle_out,
    output logic                 error_out
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_inflight;
    logic                 r_out_valid;
    logic [DATA_SIZE-1:0] r_data_vc;
    logic                 w_err;
    logic                 w_active;
    logic                 w_dest;
    logic                 w_push_vc0;
    logic                 w_push_vc1;
    logic                 w_drain;
    logic                 w_pop;
    logic                 w_cfg_sample;
    logic                 w_cfg_load;

    assign w_err        = fifo_error_main | vc0_error | vc1_error;
    assign w_active     = (r_state == ST_ACTIVE);
    assign w_dest       = r_data_vc[VC_SEL_BIT];
    assign w_cfg_sample = (r_state == ST_INIT) &  init;
    assign w_cfg_load   = (r_state == ST_INIT) & ~init;

    threshold_cfg u_threshold_cfg (
        .clk      (clk),
        .reset_L  (reset_L),
        .i_sample (w_cfg_sample),
        .i_load   (w_cfg_load),
        .i_af     (afMF_in),
        .i_ae     (aeMF_in),
        .o_af     (afMF_o),
        .o_ae     (aeMF_o)
    );

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) r_state <= ST_RESET;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push_vc0  = 1'b0;
        w_push_vc1  = 1'b0;
        w_drain     = 1'b0;
        w_pop       = 1'b0;

        case (r_state)
            ST_RESET:  w_state_nxt = ST_INIT;
            ST_INIT:   if (!init) w_state_nxt = ST_IDLE;
            ST_IDLE: begin
                if (w_err)                 w_state_nxt = ST_ERROR;
                else if (init)             w_state_nxt = ST_INIT;
                else if (!fifo_empty_main) w_state_nxt = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (w_err)
                    w_state_nxt = ST_ERROR;
                else if (fifo_empty_main && !r_inflight && !r_out_valid)
                    w_state_nxt = ST_IDLE;
            end
            ST_ERROR:  w_state_nxt = ST_ERROR;
            default:   w_state_nxt = ST_RESET;
        endcase

        // A pending word only goes to its own VC; an error cycle suppresses the push.
        w_push_vc0 = w_active & ~w_err & r_out_valid & ~w_dest & ~vc0_pause;
        w_push_vc1 = w_active & ~w_err & r_out_valid &  w_dest & ~vc1_pause;
        w_drain    = w_push_vc0 | w_push_vc1;
        w_pop      = w_active & ~fifo_empty_main & ~r_inflight & (~r_out_valid | w_drain);
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_inflight  <= 1'b0;
            r_out_valid <= 1'b0;
            r_data_vc   <= '0;
        end else begin
            r_inflight <= w_pop;
            if (r_inflight && w_active && !w_err) begin
                r_out_valid <= 1'b1;
                r_data_vc   <= data_demux_vc;
            end else if (w_drain || !w_active) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef POP_STATS_EN
    logic [7:0] r_cnt_vc0;
    logic [7:0] r_cnt_vc1;
    logic       w_init_entry;

    assign w_init_entry = (w_state_nxt == ST_INIT) && (r_state != ST_INIT);

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_cnt_vc0 <= '0;
            r_cnt_vc1 <= '0;
        end else if (w_init_entry) begin
            r_cnt_vc0 <= '0;
            r_cnt_vc1 <= '0;
        end else begin
            if (w_push_vc0 && (r_cnt_vc0 != 8'hFF)) r_cnt_vc0 <= r_cnt_vc0 + 8'd1;
            if (w_push_vc1 && (r_cnt_vc1 != 8'hFF)) r_cnt_vc1 <= r_cnt_vc1 + 8'd1;
        end
    end

    assign cnt_vc0 = r_cnt_vc0;
    assign cnt_vc1 = r_cnt_vc1;
`endif

    assign pop_main  = w_pop;
    assign push_vc0  = w_push_vc0;
    assign push_vc1  = w_push_vc1;
    assign data_vc   = r_data_vc;
    assign state     = r_state;
    assign idle_out  = (r_state == ST_IDLE);
    assign error_out = (r_state == ST_ERROR);

endmodule
